// File: rtl/ctrl_pkg.sv
// Shared Control Unit definitions: opcode indices, sequencer states, trap causes
// and the sub-FSM class used to route each instruction.
package ctrl_pkg;

    // Opcode indices are ins[6:2] of the RV base encoding.
    localparam logic [4:0] OPC_LOAD      = 5'd0;
    localparam logic [4:0] OPC_LOAD_FP   = 5'd1;
    localparam logic [4:0] OPC_OP_IMM    = 5'd4;
    localparam logic [4:0] OPC_AUIPC     = 5'd5;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'd6;
    localparam logic [4:0] OPC_STORE     = 5'd8;
    localparam logic [4:0] OPC_STORE_FP  = 5'd9;
    localparam logic [4:0] OPC_OP        = 5'd12;
    localparam logic [4:0] OPC_LUI       = 5'd13;
    localparam logic [4:0] OPC_OP_32     = 5'd14;
    localparam logic [4:0] OPC_OP_FP     = 5'd20;
    localparam logic [4:0] OPC_BRANCH    = 5'd24;
    localparam logic [4:0] OPC_JALR      = 5'd25;
    localparam logic [4:0] OPC_JAL       = 5'd27;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_WAIT     = 3'd3,
        ST_TRAP     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_TIMEOUT = 2'b10
    } trap_cause_e;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_MEM    = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_FP     = 3'd5
    } op_class_e;

    function automatic op_class_e opc_class(input logic [4:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32,
            OPC_OP, OPC_LUI, OPC_OP_32:              return CLS_ALU;
            OPC_LOAD, OPC_LOAD_FP,
            OPC_STORE, OPC_STORE_FP:                 return CLS_MEM;
            OPC_BRANCH:                              return CLS_BRANCH;
            OPC_JALR, OPC_JAL:                       return CLS_JUMP;
            OPC_OP_FP:                               return CLS_FP;
            default:                                 return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fsm_fetch_dispatch_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and imem (slave).
interface fsm_fetch_dispatch_if #(
    parameter int unsigned XLEN = 64
);
    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/op_onehot.sv
// Combinational opcode decode: one-hot code vector, owning sub-FSM class and
// illegal flag. Illegal encodings produce an all-zero code.
module op_onehot
    import ctrl_pkg::*;
(
    input  logic [6:0]  op,
    output logic [31:0] code,
    output op_class_e   op_class,
    output logic        illegal
);

    always_comb begin
        op_class = opc_class(op[6:2]);
        illegal  = (op[1:0] != 2'b11) || (op_class == CLS_NONE);
        code     = illegal ? '0 : (32'd1 << op[6:2]);
    end

endmodule

// File: rtl/fsm_fetch_dispatch.sv
// Control Unit top sequencer: fetch, decode, dispatch one start pulse to the
// owning sub-FSM, then wait for its PC update; traps on illegal ops and timeouts.
module fsm_fetch_dispatch
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned XLEN    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [XLEN-1:0]     pc,
    fsm_fetch_dispatch_if.master imem,
    input  logic                pc_done,
    output logic [31:0]         ins,
    output logic [31:0]         code,
    output logic                start_alu,
    output logic                start_mem,
    output logic                start_branch,
    output logic                start_jump,
    output logic                start_fp,
    output logic                busy,
    output logic [1:0]          trap_cause
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e     state;
    logic [7:0] wait_cnt;
    logic [31:0] dec_code;
    op_class_e  dec_class;
    logic       dec_illegal;

    op_onehot u_op_onehot (
        .op       (ins[6:0]),
        .code     (dec_code),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    // Request is suppressed while reset is held so the reset cycle issues no fetch.
    assign imem.imem_addr = pc;
    assign imem.imem_req  = rst_n && (state == ST_FETCH);
    assign busy           = (state != ST_TRAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_FETCH;
            ins          <= '0;
            code         <= '0;
            start_alu    <= 1'b0;
            start_mem    <= 1'b0;
            start_branch <= 1'b0;
            start_jump   <= 1'b0;
            start_fp     <= 1'b0;
            trap_cause   <= TRAP_NONE;
            wait_cnt     <= '0;
        end else begin
            start_alu    <= 1'b0;
            start_mem    <= 1'b0;
            start_branch <= 1'b0;
            start_jump   <= 1'b0;
            start_fp     <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        ins   <= imem.imem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        code       <= '0;
                        trap_cause <= TRAP_ILLEGAL;
                        state      <= ST_TRAP;
                    end else begin
                        code         <= dec_code;
                        start_alu    <= (dec_class == CLS_ALU);
                        start_mem    <= (dec_class == CLS_MEM);
                        start_branch <= (dec_class == CLS_BRANCH);
                        start_jump   <= (dec_class == CLS_JUMP);
                        start_fp     <= (dec_class == CLS_FP);
                        state        <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // wait_cnt holds completed WAIT cycles, so +1 counts the current one.
                    wait_cnt <= wait_cnt + 8'd1;
                    if (pc_done) begin
                        state <= ST_FETCH;
                    end else if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
                        trap_cause <= TRAP_TIMEOUT;
                        state      <= ST_TRAP;
                    end
                end
                ST_TRAP: begin
                    state <= ST_TRAP;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_fetch_dispatch.sv
// Randomized self-checking bench for fsm_fetch_dispatch against a phase-level
// reference of the fetch/decode/dispatch/wait sequence.
module tb_fsm_fetch_dispatch;

    localparam int unsigned TB_TIMEOUT = 15;
    localparam int unsigned TB_XLEN    = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [TB_XLEN-1:0] pc;
    logic               pc_done;
    logic [31:0]        ins;
    logic [31:0]        code;
    logic               start_alu, start_mem, start_branch, start_jump, start_fp;
    logic               busy;
    logic [1:0]         trap_cause;
    logic [4:0]         starts_obs;

    always #5 clk = ~clk;

    fsm_fetch_dispatch_if #(.XLEN(TB_XLEN)) imem_bus ();

    fsm_fetch_dispatch #(
        .TIMEOUT (TB_TIMEOUT),
        .XLEN    (TB_XLEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .imem         (imem_bus),
        .pc_done      (pc_done),
        .ins          (ins),
        .code         (code),
        .start_alu    (start_alu),
        .start_mem    (start_mem),
        .start_branch (start_branch),
        .start_jump   (start_jump),
        .start_fp     (start_fp),
        .busy         (busy),
        .trap_cause   (trap_cause)
    );

    assign starts_obs = {start_fp, start_jump, start_branch, start_mem, start_alu};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_ins;
    logic [31:0] exp_code;
    logic [1:0]  exp_trap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Class: 0 illegal, 1 ALU, 2 MEM, 3 BRANCH, 4 JUMP, 5 FP
    function automatic int op_class(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 0;
        case (int'(w[6:2]))
            4, 5, 6, 12, 13, 14: return 1;
            0, 1, 8, 9:          return 2;
            24:                  return 3;
            25, 27:              return 4;
            20:                  return 5;
            default:             return 0;
        endcase
    endfunction

    function automatic logic [4:0] starts_for(input int cls);
        logic [4:0] v;
        v = '0;
        if (cls > 0) v[cls-1] = 1'b1;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_side_inputs();
        imem_bus.imem_ready = 1'($urandom_range(0, 1));
        imem_bus.imem_rdata = $urandom;
        pc_done             = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_cycle(input string ph, input logic req, input logic [4:0] st, input logic bsy);
        chk({ph, ".req"},   imem_bus.imem_req, req);
        if (req) chk({ph, ".addr"}, imem_bus.imem_addr, pc);
        chk({ph, ".start"}, starts_obs, st);
        chk({ph, ".busy"},  busy, bsy);
        chk({ph, ".ins"},   ins, exp_ins);
        chk({ph, ".code"},  code, exp_code);
        chk({ph, ".trap"},  trap_cause, exp_trap);
    endtask

    // Called with rst_n already low in the current cycle; returns with rst_n
    // released at the start of the first post-reset FETCH cycle.
    task automatic reset_tail();
        next_cycle();
        rand_side_inputs();
        #1;
        exp_ins  = '0;
        exp_code = '0;
        exp_trap = 2'b00;
        chk_cycle("reset", 1'b0, 5'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic hold_trap(input string ph);
        for (int i = 0; i < 20; i++) begin
            rand_side_inputs();
            #1;
            chk_cycle(ph, 1'b0, 5'b0, 1'b0);
            next_cycle();
        end
        rst_n = 1'b0;
        reset_tail();
    endtask

    // done_at: WAIT cycle (1-based) carrying pc_done, 0 = never.
    // cut: 0 none, 1 reset during DISPATCH, 2 reset during the 2nd WAIT cycle.
    task automatic run_insn(input logic [31:0] w, input int unsigned rdy_delay,
                            input int unsigned done_at, input int unsigned cut);
        int cls;
        cls = op_class(w);
        for (int unsigned k = 0; k <= rdy_delay; k++) begin
            pc                  = {$urandom, $urandom};
            imem_bus.imem_ready = (k == rdy_delay);
            imem_bus.imem_rdata = (k == rdy_delay) ? w : $urandom;
            pc_done             = 1'($urandom_range(0, 1));
            #1;
            chk_cycle("fetch", 1'b1, 5'b0, 1'b1);
            next_cycle();
        end
        exp_ins = w;
        rand_side_inputs();
        #1;
        chk_cycle("decode", 1'b0, 5'b0, 1'b1);
        next_cycle();
        if (cls == 0) begin
            exp_code = '0;
            exp_trap = 2'b01;
            hold_trap("illegal");
            return;
        end
        exp_code = 32'd1 << w[6:2];
        rand_side_inputs();
        rst_n = (cut != 1);
        #1;
        chk_cycle("dispatch", 1'b0, starts_for(cls), 1'b1);
        if (cut == 1) begin
            reset_tail();
            return;
        end
        next_cycle();
        for (int unsigned wc = 1; wc <= TB_TIMEOUT; wc++) begin
            imem_bus.imem_ready = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            pc_done             = (wc == done_at);
            rst_n               = !(cut == 2 && wc == 2);
            #1;
            chk_cycle("wait", 1'b0, 5'b0, 1'b1);
            if (cut == 2 && wc == 2) begin
                reset_tail();
                return;
            end
            next_cycle();
            if (wc == done_at) return;
        end
        exp_trap = 2'b10;
        hold_trap("timeout");
    endtask

    logic [4:0] legal_idx [14] = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9,
                                   5'd12, 5'd13, 5'd14, 5'd20, 5'd24, 5'd25, 5'd27};

    initial begin
        logic [31:0] rw;
        int unsigned done_at, cut;
        rst_n               = 1'b0;
        pc                  = 64'h1000;
        pc_done             = 1'b0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = '0;
        exp_ins             = '0;
        exp_code            = '0;
        exp_trap            = 2'b00;
        #2;
        reset_tail();

        run_insn(32'h003100B3, 0, 3, 0);              // ADD
        run_insn(32'h00001097, 0, 2, 0);              // AUIPC
        run_insn(32'h0000000B, 0, 0, 0);              // custom-0: illegal
        run_insn(32'h0000006F, 0, 0, 0);              // JAL, never completes
        run_insn(32'h0000006F, 0, TB_TIMEOUT, 0);     // JAL, done on the last cycle
        run_insn(32'h00002003, 3, 1, 0);              // LOAD with slow imem
        run_insn(32'h00000063, 1, 0, 1);              // BRANCH cut in DISPATCH
        run_insn(32'h00000053, 0, 0, 2);              // OP-FP cut in WAIT
        run_insn(32'h00000023, 2, 4, 0);              // STORE after cut

        for (int n = 0; n < 60; n++) begin
            rw = $urandom;
            if ($urandom_range(0, 9) < 8)
                rw[6:0] = {legal_idx[$urandom_range(0, 13)], 2'b11};
            done_at = $urandom_range(1, TB_TIMEOUT + 2);
            cut     = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
            if (cut != 0) done_at = 0;
            run_insn(rw, $urandom_range(0, 3), done_at, cut);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
